serial_edge_sampler: RTL
========================

# serial_edge_sampler

Front-end stage that sits directly upstream of the serial read buffer. It synchronizes an external serial bus (clock, data, chip-select) into the sys_clk domain and detects the configured sampling edge of the serial clock. It produces single-cycle read strobes with the aligned data bit, plus frame start, end and timeout events. Its read_sig and data_bit outputs connect straight to the buffer's read_sig and data_in; frame_start drives the buffer's start.

## Interface
- SYNC_STAGES, 2, flip-flop depth of each input synchronizer (≥2)
- SAMPLE_RISING, 1, 1 = sample on serial clock rising edge, 0 = falling edge
- CS_ACTIVE_LOW, 1, polarity of ser_cs_in
- CS_USED, 1, 0 = no chip-select; frames are delimited by the idle timeout only
- MAX_BITS, 64, saturation value of bit_count
- IDLE_TIMEOUT, 255, sys_clk cycles without a sampling edge before the frame is declared stale (≥1)

Ports:
- sys_clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- enable  in  1  synchronous enable; while low, no new frame starts
- ser_clk_in  in  1  raw serial clock, asynchronous
- ser_data_in  in  1  raw serial data, asynchronous
- ser_cs_in  in  1  raw chip-select, asynchronous (ignored when CS_USED=0)
- read_sig  out  1  one-cycle strobe: data_bit is valid this cycle
- data_bit  out  1  sampled data bit; held until the next read_sig
- frame_start  out  1  one-cycle pulse on frame entry
- frame_active  out  1  high while in ACTIVE
- frame_end  out  1  one-cycle pulse on normal frame termination
- timeout  out  1  one-cycle pulse on idle-timeout termination
- bit_count  out  $clog2(MAX_BITS+1)  read_sig count in the current frame, saturating at MAX_BITS

## Operation
- Inputs pass through an identical SYNC_STAGES chain each, so clk, data and cs stay mutually aligned. One extra register holds the previous synced clk value for edge detection.
- Synchronizer reset values are the idle levels: clk = ~SAMPLE_RISING (no spurious edge), cs = inactive, data = 0.
- An edge is a transition of synced clk in the direction selected by SAMPLE_RISING.
- States:
  - RESET: entered on rst. After rst deasserts, spends exactly one sys_clk cycle clearing bit_count, the idle counter and data_bit, then goes to ARMED.
  - ARMED: with CS_USED=1, waits until synced cs is seen inactive at least once, so the block never joins a frame mid-way. Goes to IDLE. With CS_USED=0, goes to IDLE immediately.
  - IDLE:
    - CS_USED=1: cs becoming active with enable=1 -> pulse frame_start, go to ACTIVE.
    - CS_USED=0: first edge with enable=1 -> pulse frame_start and treat that edge as bit 0 (read_sig in the same cycle), go to ACTIVE.
  - ACTIVE: each edge -> read_sig=1, data_bit=synced data, bit_count+1 (saturating), idle counter cleared. With no edge, the idle counter increments.
    - cs inactive (CS_USED=1) -> pulse frame_end, go to IDLE.
    - Idle counter reaching IDLE_TIMEOUT -> pulse timeout, go to IDLE. With CS_USED=1, also go through ARMED.
  - On entering ACTIVE, bit_count and the idle counter clear.
- enable falling during ACTIVE does not abort the frame; it only blocks the next frame_start.

## Timing
- Reset values: read_sig=0, data_bit=0, frame_start=0, frame_active=0, frame_end=0, timeout=0, bit_count=0.
- Latency from a raw pin transition to the corresponding output pulse: SYNC_STAGES+1 sys_clk cycles, for both read_sig and frame_start.
- Serial clock high and low phases must each be ≥ SYNC_STAGES+1 sys_clk periods; faster clocks are out of spec and edges may be lost.
- Simultaneous events, same cycle:
  - Sampling edge and cs deassert: the edge is dropped; frame_end fires.
  - cs assert and edge (CS_USED=1): frame_start fires; the edge is dropped.
  - Edge on the timeout cycle: the edge wins; the counter clears and no timeout fires.
- All pulses are exactly one cycle. frame_start, frame_end and timeout are mutually exclusive in any cycle.
- rst mid-frame: all outputs clear asynchronously. No frame_end or timeout is emitted.

## Structure
- Shared package serial_pkg: state encoding (RESET, ARMED, IDLE, ACTIVE as 2-bit constants) and a width function for bit and idle counters.
- Sub-module sync_chain (parameter STAGES, RESET_VAL): N-flop synchronizer, instantiated three times.
- Edge detect, FSM and counters live in the top module.

## Test plan
- Reset exit with cs held active (CS_USED=1): no frame_start until cs goes inactive then active again; all outputs 0 meanwhile.
- 8 rising edges, data 0xA5 MSB-first, SYNC_STAGES=2: 8 read_sig pulses, each 3 cycles after its raw edge; data_bit sequence 1,0,1,0,0,1,0,1; bit_count=8; frame_end 3 cycles after cs deassert.
- SAMPLE_RISING=0: the same stimulus yields strobes on falling edges only; no strobe at frame entry.
- CS_USED=0, IDLE_TIMEOUT=20: 4 edges, then silence. frame_start coincides with the first read_sig; timeout pulses exactly 20 cycles after the last edge; frame_active then drops.
- MAX_BITS=4 with 6 edges: bit_count holds at 4, while read_sig still pulses 6 times.
- rst asserted after bit 3: outputs clear immediately. The next frame starts with bit_count=0, preceded by the one-cycle RESET state.

Source files
------------

// File: rtl/serial_edge_sampler_pkg.sv
// Shared definitions for the serial front-end: FSM state encoding and
// counter width helper.
package serial_pkg;

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_ARMED  = 2'd1,
    ST_IDLE   = 2'd2,
    ST_ACTIVE = 2'd3
  } state_t;

  // Bits needed to hold the values 0..max_val inclusive (never less than one).
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/serial_edge_sampler_sync_chain.sv
// N-flop synchronizer for one asynchronous input; resets to the line's idle level.
module sync_chain #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic sys_clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic [STAGES-1:0] sync_r;

  // shift the raw input through the synchronizer flops
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      sync_r <= {STAGES{RESET_VAL}};
    end else begin
      sync_r <= {sync_r[STAGES-2:0], din};
    end
  end

  assign dout = sync_r[STAGES-1];

endmodule

// File: rtl/serial_edge_sampler.sv
// Serial bus front-end: synchronizes clk/data/cs into sys_clk, detects the sampling
// edge and frames the bit stream into read strobes plus start/end/timeout events.
module serial_edge_sampler
  import serial_pkg::*;
#(
  parameter int   SYNC_STAGES   = 2,
  parameter logic SAMPLE_RISING = 1'b1,
  parameter logic CS_ACTIVE_LOW = 1'b1,
  parameter logic CS_USED       = 1'b1,
  parameter int   MAX_BITS      = 64,
  parameter int   IDLE_TIMEOUT  = 255
) (
  input  logic                           sys_clk,
  input  logic                           rst,
  input  logic                           enable,
  input  logic                           ser_clk_in,
  input  logic                           ser_data_in,
  input  logic                           ser_cs_in,
  output logic                           read_sig,
  output logic                           data_bit,
  output logic                           frame_start,
  output logic                           frame_active,
  output logic                           frame_end,
  output logic                           timeout,
  output logic [$clog2(MAX_BITS+1)-1:0]  bit_count
);

  localparam int   BW       = $clog2(MAX_BITS + 1);
  localparam int   IW       = cnt_width(IDLE_TIMEOUT);
  localparam int   FW       = cnt_width(SYNC_STAGES);
  localparam logic CLK_IDLE = ~SAMPLE_RISING;

  logic          clk_s, data_s, cs_raw_s, cs_act_s;
  logic          edge_s, cs_start_s, fill_done_s;
  logic          clk_prev_r, cs_prev_r;
  logic [FW-1:0] fill_r;
  state_t        state_r, state_nxt_s;
  logic [BW-1:0] bit_cnt_r, bit_cnt_nxt_s;
  logic [IW-1:0] idle_cnt_r, idle_cnt_nxt_s;
  logic          data_r, data_nxt_s;
  logic          rd_nxt_s, fs_nxt_s, fe_nxt_s, to_nxt_s;

  sync_chain #(.STAGES(SYNC_STAGES), .RESET_VAL(CLK_IDLE)) u_sync_clk (
    .sys_clk(sys_clk), .rst(rst), .din(ser_clk_in), .dout(clk_s)
  );
  sync_chain #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_data (
    .sys_clk(sys_clk), .rst(rst), .din(ser_data_in), .dout(data_s)
  );
  sync_chain #(.STAGES(SYNC_STAGES), .RESET_VAL(CS_ACTIVE_LOW)) u_sync_cs (
    .sys_clk(sys_clk), .rst(rst), .din(ser_cs_in), .dout(cs_raw_s)
  );

  assign cs_act_s    = cs_raw_s ^ CS_ACTIVE_LOW;
  assign edge_s      = SAMPLE_RISING ? (clk_s & ~clk_prev_r) : (~clk_s & clk_prev_r);
  assign cs_start_s  = cs_act_s & ~cs_prev_r;
  // The cs chain only carries real pin values once it has been refilled after reset;
  // until then its "inactive" reset level must not release ARMED.
  assign fill_done_s = (fill_r == FW'(SYNC_STAGES));

  // edge-detect history and post-reset synchronizer fill tracking
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      clk_prev_r <= CLK_IDLE;
      cs_prev_r  <= 1'b0;
      fill_r     <= '0;
    end else begin
      clk_prev_r <= clk_s;
      cs_prev_r  <= cs_act_s;
      if (!fill_done_s) begin
        fill_r <= fill_r + FW'(1'b1);
      end
    end
  end

  // next-state, counter and strobe decisions
  always_comb begin
    state_nxt_s    = state_r;
    bit_cnt_nxt_s  = bit_cnt_r;
    idle_cnt_nxt_s = idle_cnt_r;
    data_nxt_s     = data_r;
    rd_nxt_s       = 1'b0;
    fs_nxt_s       = 1'b0;
    fe_nxt_s       = 1'b0;
    to_nxt_s       = 1'b0;
    case (state_r)
      ST_RESET: begin
        bit_cnt_nxt_s  = '0;
        idle_cnt_nxt_s = '0;
        data_nxt_s     = 1'b0;
        state_nxt_s    = ST_ARMED;
      end
      ST_ARMED: begin
        if (!CS_USED || (fill_done_s && !cs_act_s)) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_ARMED;
        end
      end
      ST_IDLE: begin
        if (CS_USED) begin
          if (cs_start_s && enable) begin
            fs_nxt_s       = 1'b1;
            bit_cnt_nxt_s  = '0;
            idle_cnt_nxt_s = '0;
            state_nxt_s    = ST_ACTIVE;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          // without cs the opening edge is already bit 0 of the frame
          if (edge_s && enable) begin
            fs_nxt_s       = 1'b1;
            rd_nxt_s       = 1'b1;
            data_nxt_s     = data_s;
            bit_cnt_nxt_s  = BW'(1'b1);
            idle_cnt_nxt_s = '0;
            state_nxt_s    = ST_ACTIVE;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
      end
      ST_ACTIVE: begin
        if (CS_USED && !cs_act_s) begin
          fe_nxt_s    = 1'b1;
          state_nxt_s = ST_IDLE;
        end else if (edge_s) begin
          rd_nxt_s       = 1'b1;
          data_nxt_s     = data_s;
          idle_cnt_nxt_s = '0;
          if (bit_cnt_r != BW'(MAX_BITS)) begin
            bit_cnt_nxt_s = bit_cnt_r + BW'(1'b1);
          end else begin
            bit_cnt_nxt_s = bit_cnt_r;
          end
        end else if (idle_cnt_r == IW'(IDLE_TIMEOUT - 1)) begin
          to_nxt_s    = 1'b1;
          state_nxt_s = CS_USED ? ST_ARMED : ST_IDLE;
        end else begin
          idle_cnt_nxt_s = idle_cnt_r + IW'(1'b1);
        end
      end
      default: begin
        state_nxt_s = ST_RESET;
      end
    endcase
  end

  // FSM state, counters and held data bit
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_RESET;
      bit_cnt_r  <= '0;
      idle_cnt_r <= '0;
      data_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      bit_cnt_r  <= bit_cnt_nxt_s;
      idle_cnt_r <= idle_cnt_nxt_s;
      data_r     <= data_nxt_s;
    end
  end

  // registered strobes and frame status
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      read_sig     <= 1'b0;
      frame_start  <= 1'b0;
      frame_end    <= 1'b0;
      timeout      <= 1'b0;
      frame_active <= 1'b0;
    end else begin
      read_sig     <= rd_nxt_s;
      frame_start  <= fs_nxt_s;
      frame_end    <= fe_nxt_s;
      timeout      <= to_nxt_s;
      frame_active <= (state_nxt_s == ST_ACTIVE);
    end
  end

  assign data_bit  = data_r;
  assign bit_count = bit_cnt_r;

endmodule
